// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// default busy durations.
package mult_div_unit_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   localparam int DEFAULT_MULT_CYCLES = 5;
   localparam int DEFAULT_DIV_CYCLES  = 10;
   localparam int CNT_W               = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_t;

endpackage

// File: rtl/mult_div_unit_arith.sv
// Combinational result generator: packs {hi, lo} for multiply and
// {remainder, quotient} for divide, and flags a zero divisor.
module md_arith
   import mult_div_unit_pkg::*;
(
   input  logic [2:0]  i_op,
   input  logic [31:0] i_src_a,
   input  logic [31:0] i_src_b,
   output logic [63:0] o_result,
   output logic        o_div_zero
);

   logic [63:0] w_mul_signed;
   logic [63:0] w_mul_unsigned;
   logic        w_div_signed;
   logic        w_neg_a;
   logic        w_neg_b;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [31:0] w_divisor;
   logic [31:0] w_quot_mag;
   logic [31:0] w_rem_mag;
   logic [31:0] w_quot;
   logic [31:0] w_rem;

   assign w_mul_signed   = {{32{i_src_a[31]}}, i_src_a} * {{32{i_src_b[31]}}, i_src_b};
   assign w_mul_unsigned = {32'd0, i_src_a} * {32'd0, i_src_b};

   // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly
   // to 0x80000000 instead of hitting an overflowing signed division.
   assign w_div_signed = (i_op == MD_DIV);
   assign w_neg_a      = w_div_signed & i_src_a[31];
   assign w_neg_b      = w_div_signed & i_src_b[31];
   assign w_mag_a      = w_neg_a ? (32'd0 - i_src_a) : i_src_a;
   assign w_mag_b      = w_neg_b ? (32'd0 - i_src_b) : i_src_b;
   assign w_divisor    = (i_src_b == 32'd0) ? 32'd1 : w_mag_b;
   assign w_quot_mag   = w_mag_a / w_divisor;
   assign w_rem_mag    = w_mag_a % w_divisor;
   assign w_quot       = (w_neg_a ^ w_neg_b) ? (32'd0 - w_quot_mag) : w_quot_mag;
   assign w_rem        = w_neg_a ? (32'd0 - w_rem_mag) : w_rem_mag;

   always_comb begin
      o_result   = 64'd0;
      o_div_zero = 1'b0;
      case (i_op)
         MD_MULT:  o_result = w_mul_signed;
         MD_MULTU: o_result = w_mul_unsigned;
         MD_DIV, MD_DIVU: begin
            o_result   = {w_rem, w_quot};
            o_div_zero = (i_src_b == 32'd0);
         end
         default:  o_result = 64'd0;
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO. The result is
// computed at start and held pending until the busy period expires.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_t        r_state;
   md_state_t        w_next_state;
   logic [CNT_W-1:0] r_count;
   logic [31:0]      r_pend_hi;
   logic [31:0]      r_pend_lo;
   logic             r_pend_write;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;

   logic [63:0]      w_result;
   logic             w_div_zero;
   logic             w_accept_long;
   logic             w_commit;

   md_arith u_arith (
      .i_op       (op),
      .i_src_a    (src_a),
      .i_src_b    (src_b),
      .o_result   (w_result),
      .o_div_zero (w_div_zero)
   );

   always_comb begin
      w_next_state  = r_state;
      w_accept_long = 1'b0;
      w_commit      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && !op[2]) begin
               w_next_state  = RUN;
               w_accept_long = 1'b1;
            end
         end
         RUN: begin
            if (r_count == CNT_W'(1)) begin
               w_next_state = IDLE;
               w_commit     = 1'b1;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Moves (MTHI/MTLO) only land while idle; anything arriving mid-run is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_count      <= '0;
         r_pend_hi    <= '0;
         r_pend_lo    <= '0;
         r_pend_write <= 1'b0;
         r_hi         <= '0;
         r_lo         <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept_long) begin
            r_count      <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            r_pend_hi    <= w_result[63:32];
            r_pend_lo    <= w_result[31:0];
            r_pend_write <= !w_div_zero;
         end else if (r_state == RUN) begin
            r_count <= r_count - CNT_W'(1);
         end
         if (w_commit && r_pend_write) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
         end
         if (r_state == IDLE && start && op == MD_MTHI) begin
            r_hi <= src_a;
         end
         if (r_state == IDLE && start && op == MD_MTLO) begin
            r_lo <= src_a;
         end
      end
   end

   assign busy = (r_state == RUN);
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed results.
module tb_mult_div_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   mult_div_unit dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Issues one op, then checks busy for the whole expected busy period and its fall.
   task automatic applyStimulus(input string tag, input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] b, input int cycles);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      step();
      start = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         checkOutput({tag, "_busy_hi"}, {31'd0, busy}, 32'd1);
         step();
      end
      checkOutput({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 3'd0;
      src_a = 32'd0;
      src_b = 32'd0;
      step();
      step();
      reset = 1'b0;
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_hi", hi, 32'd0);
      checkOutput("reset_lo", lo, 32'd0);

      // MULT -2 * 3, including a check that LO is untouched in the last busy cycle
      start = 1'b1; op = 3'd0; src_a = 32'hFFFF_FFFE; src_b = 32'd3;
      step();
      start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         checkOutput("mult_busy_hi", {31'd0, busy}, 32'd1);
         if (i == 5) checkOutput("mult_no_early_commit", lo, 32'd0);
         step();
      end
      checkOutput("mult_busy_lo", {31'd0, busy}, 32'd0);
      checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
      checkOutput("mult_lo", lo, 32'hFFFF_FFFA);

      applyStimulus("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
      checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
      checkOutput("multu_lo", lo, 32'h0000_0001);

      applyStimulus("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10);
      checkOutput("div_hi", hi, 32'hFFFF_FFFF);
      checkOutput("div_lo", lo, 32'hFFFF_FFFD);

      applyStimulus("divu", 3'd3, 32'd7, 32'd2, 10);
      checkOutput("divu_hi", hi, 32'd1);
      checkOutput("divu_lo", lo, 32'd3);

      applyStimulus("mthi", 3'd4, 32'h1234_5678, 32'd0, 0);
      checkOutput("mthi_hi", hi, 32'h1234_5678);
      applyStimulus("mtlo", 3'd5, 32'h9ABC_DEF0, 32'd0, 0);
      checkOutput("mtlo_lo", lo, 32'h9ABC_DEF0);
      checkOutput("mtlo_hi_kept", hi, 32'h1234_5678);

      applyStimulus("nop6", 3'd6, 32'h5555_5555, 32'd1, 0);
      checkOutput("nop6_hi", hi, 32'h1234_5678);
      checkOutput("nop6_lo", lo, 32'h9ABC_DEF0);

      applyStimulus("divzero", 3'd2, 32'd100, 32'd0, 10);
      checkOutput("divzero_hi", hi, 32'h1234_5678);
      checkOutput("divzero_lo", lo, 32'h9ABC_DEF0);

      applyStimulus("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10);
      checkOutput("divovf_hi", hi, 32'd0);
      checkOutput("divovf_lo", lo, 32'h8000_0000);

      // MTLO issued while busy must be ignored
      start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd4;
      step();
      start = 1'b0;
      step();
      start = 1'b1; op = 3'd5; src_a = 32'h0000_DEAD; src_b = 32'd0;
      step();
      start = 1'b0;
      checkOutput("ignored_lo_mid", lo, 32'h8000_0000);
      checkOutput("ignored_busy_mid", {31'd0, busy}, 32'd1);
      step();
      step();
      step();
      checkOutput("ignored_busy_lo", {31'd0, busy}, 32'd0);
      checkOutput("ignored_hi", hi, 32'd0);
      checkOutput("ignored_lo", lo, 32'd12);

      // Reset mid-operation discards the pending result
      start = 1'b1; op = 3'd0; src_a = 32'hFFFF_FFFE; src_b = 32'd3;
      step();
      start = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
      checkOutput("midreset_hi", hi, 32'd0);
      checkOutput("midreset_lo", lo, 32'd0);
      for (int i = 0; i < 6; i++) step();
      checkOutput("midreset_busy_after", {31'd0, busy}, 32'd0);
      checkOutput("midreset_hi_after", hi, 32'd0);
      checkOutput("midreset_lo_after", lo, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
